// File: rtl/dii_worm_rr_arbiter.sv
// rtl/dii_worm_rr_arbiter.sv - wormhole-aware round-robin arbiter/mux for DII flit streams
package dii_pkg;
    typedef struct packed {
        logic        valid;
        logic        last;
        logic [15:0] data;
    } dii_flit;
endpackage

module dii_worm_rr_arbiter
    import dii_pkg::*;
#(
    parameter int N_INPUTS = 3,
    parameter int TIMEOUT  = 256
) (
    input  logic                clk,
    input  logic                rst,
    input  dii_flit             in_flit [N_INPUTS],
    output logic [N_INPUTS-1:0] in_ready,
    input  logic [N_INPUTS-1:0] in_enable,
    output dii_flit             out_flit,
    input  logic                out_ready,
    output logic [N_INPUTS-1:0] grant,
    output logic                locked,
    output logic                err_timeout,
    input  logic                err_clear
);
    localparam int PTR_W = $clog2(N_INPUTS);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t           state, state_next;
    logic [PTR_W-1:0] ptr, ptr_next;
    logic [PTR_W-1:0] owner, owner_next;
    logic [CNT_W-1:0] starve_cnt, starve_cnt_next;
    logic             err_next;

    logic [PTR_W-1:0] scan_idx [N_INPUTS];
    logic [PTR_W-1:0] cand, sel;
    logic             cand_found, active, xfer, starving;
    dii_flit          sel_flit;

    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] x);
        return (int'(x) == N_INPUTS - 1) ? '0 : x + PTR_W'(1);
    endfunction

    // Circular search starting at ptr; modulo keeps non-power-of-two counts in range.
    always_comb begin
        cand       = '0;
        cand_found = 1'b0;
        for (int k = 0; k < N_INPUTS; k++) begin
            scan_idx[k] = PTR_W'((int'(ptr) + k) % N_INPUTS);
        end
        for (int k = 0; k < N_INPUTS; k++) begin
            if (!cand_found && in_flit[scan_idx[k]].valid && in_enable[scan_idx[k]]) begin
                cand_found = 1'b1;
                cand       = scan_idx[k];
            end
        end
    end

    always_comb begin
        sel      = (state == LOCKED) ? owner : cand;
        active   = !rst && ((state == LOCKED) || cand_found);
        sel_flit = in_flit[sel];
        out_flit = '0;
        grant    = '0;
        in_ready = '0;
        if (active) begin
            grant[sel]    = 1'b1;
            in_ready[sel] = out_ready;
            if (sel_flit.valid) begin
                out_flit = sel_flit;
            end
        end
        locked   = !rst && (state == LOCKED);
        xfer     = active && sel_flit.valid && out_ready;
        starving = (state == LOCKED) && !in_flit[owner].valid;
    end

    // An unaccepted idle offer still locks, so the granted source stays held under backpressure.
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        owner_next = owner;
        case (state)
            IDLE: begin
                if (cand_found) begin
                    if (xfer && sel_flit.last) begin
                        ptr_next = wrap_inc(cand);
                    end else begin
                        state_next = LOCKED;
                        owner_next = cand;
                    end
                end
            end
            LOCKED: begin
                if (xfer && sel_flit.last) begin
                    state_next = IDLE;
                    ptr_next   = wrap_inc(owner);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        starve_cnt_next = '0;
        if (starving) begin
            starve_cnt_next = (starve_cnt == CNT_MAX) ? starve_cnt : starve_cnt + CNT_W'(1);
        end
        err_next = err_timeout;
        if (err_clear) begin
            err_next = 1'b0;
        end else if ((TIMEOUT > 0) && starving && (starve_cnt_next == CNT_MAX)) begin
            err_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            owner       <= '0;
            starve_cnt  <= '0;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_next;
            ptr         <= ptr_next;
            owner       <= owner_next;
            starve_cnt  <= starve_cnt_next;
            err_timeout <= err_next;
        end
    end
endmodule

// File: tb/tb_dii_worm_rr_arbiter.sv
// tb/tb_dii_worm_rr_arbiter.sv - randomized and directed bench for dii_worm_rr_arbiter
module tb_dii_worm_rr_arbiter;
    import dii_pkg::*;

    localparam int N   = 3;
    localparam int TMO = 4;

    logic         clk = 1'b0;
    logic         rst;
    dii_flit      in_flit [N];
    logic [N-1:0] in_ready, in_enable, grant;
    dii_flit      out_flit;
    logic         out_ready, locked, err_timeout, err_clear;

    always #5 clk = ~clk;

    dii_worm_rr_arbiter #(.N_INPUTS(N), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .in_flit(in_flit), .in_ready(in_ready),
        .in_enable(in_enable), .out_flit(out_flit), .out_ready(out_ready),
        .grant(grant), .locked(locked), .err_timeout(err_timeout), .err_clear(err_clear)
    );

    int checks = 0;
    int errors = 0;

    // Per-source flit queues ({last, data}); gap forces valid low for that source.
    logic [16:0]  srcq [N][$];
    bit           gap [N];
    logic [N-1:0] seen_ready;

    // Reference: worm owner flag, owner index, search start, starve count, sticky flag.
    bit m_busy = 0;
    int m_own  = 0;
    int m_ptr  = 0;
    int m_cnt  = 0;
    bit m_err  = 0;

    bit           exp_act, exp_locked;
    int           exp_sel;
    logic [N-1:0] exp_grant, exp_ready;
    dii_flit      exp_out;

    task automatic model_eval();
        exp_act = 0;
        exp_sel = 0;
        if (!rst) begin
            if (m_busy) begin
                exp_act = 1;
                exp_sel = m_own;
            end else begin
                for (int k = 0; k < N; k++) begin
                    int i = (m_ptr + k) % N;
                    if (!exp_act && in_flit[i].valid && in_enable[i]) begin
                        exp_act = 1;
                        exp_sel = i;
                    end
                end
            end
        end
        exp_grant = '0;
        exp_ready = '0;
        exp_out   = '0;
        if (exp_act) begin
            exp_grant[exp_sel] = 1'b1;
            exp_ready[exp_sel] = out_ready;
            if (in_flit[exp_sel].valid) exp_out = in_flit[exp_sel];
        end
        exp_locked = !rst && m_busy;
    endtask

    task automatic model_tick();
        bit xfer, lst, starving;
        int ncnt;
        if (rst) begin
            m_busy = 0; m_own = 0; m_ptr = 0; m_cnt = 0; m_err = 0;
            return;
        end
        xfer     = exp_act && in_flit[exp_sel].valid && out_ready;
        lst      = in_flit[exp_sel].last;
        starving = m_busy && !in_flit[m_own].valid;
        ncnt     = starving ? ((m_cnt < TMO) ? m_cnt + 1 : TMO) : 0;
        if (err_clear) m_err = 0;
        else if (starving && ncnt == TMO) m_err = 1;
        m_cnt = ncnt;
        if (!m_busy) begin
            if (exp_act) begin
                if (xfer && lst) m_ptr = (exp_sel + 1) % N;
                else begin
                    m_busy = 1;
                    m_own  = exp_sel;
                end
            end
        end else if (xfer && lst) begin
            m_busy = 0;
            m_ptr  = (m_own + 1) % N;
        end
    endtask

    task automatic present();
        for (int i = 0; i < N; i++) begin
            if (srcq[i].size() > 0 && !gap[i]) begin
                in_flit[i].valid = 1'b1;
                in_flit[i].last  = srcq[i][0][16];
                in_flit[i].data  = srcq[i][0][15:0];
            end else begin
                in_flit[i] = '0;
            end
        end
        model_eval();
        @(negedge clk);
        seen_ready = in_ready;
    endtask

    task automatic advance();
        @(posedge clk);
        model_tick();
        for (int i = 0; i < N; i++)
            if (seen_ready[i] && in_flit[i].valid) void'(srcq[i].pop_front());
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            srcq[i].delete();
            gap[i] = 0;
        end
        present();
        advance();
        rst = 1'b0; out_ready = 1'b1; in_enable = '1; err_clear = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; out_ready = 1'b1; in_enable = '1; err_clear = 1'b0;
        for (int i = 0; i < N; i++) srcq[i].push_back({1'b1, 16'h0100 + 16'(i)});
        present();
        checks++;
        if ({grant, in_ready, out_flit.valid, locked} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got grant=%b in_ready=%b valid=%b locked=%b, want all 0",
                     grant, in_ready, out_flit.valid, locked);
        end
        advance();
        rst = 1'b0;
        for (int i = 0; i < N; i++) srcq[i].delete();
        present();
        checks++;
        if ({grant, in_ready, out_flit, locked, err_timeout} !== '0) begin
            errors++;
            $display("FAIL reset_idle: got grant=%b in_ready=%b out=%h locked=%b err=%b, want all 0",
                     grant, in_ready, out_flit, locked, err_timeout);
        end
        advance();
    endtask

    task automatic test_round_robin();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < 2; j++) srcq[i].push_back({1'b1, 16'h1000 + 16'(i * 16 + j)});
        for (int c = 0; c < 6; c++) begin
            logic [N-1:0] want;
            want = '0;
            want[c % N] = 1'b1;
            present();
            checks++;
            if (grant !== want || {in_ready, out_flit} !== {exp_ready, exp_out}) begin
                errors++;
                $display("FAIL round_robin c%0d: got grant=%b ready=%b out=%h, want grant=%b ready=%b out=%h",
                         c, grant, in_ready, out_flit, want, exp_ready, exp_out);
            end
            advance();
        end
    endtask

    task automatic test_worm_lock();
        logic [15:0] seq [4];
        int k;
        seq = '{16'hA001, 16'hA002, 16'hA003, 16'hB001};
        k = 0;
        do_reset();
        srcq[0].push_back({1'b0, 16'hA001});
        srcq[0].push_back({1'b0, 16'hA002});
        srcq[0].push_back({1'b1, 16'hA003});
        for (int c = 0; c < 6; c++) begin
            if (c == 1) srcq[2].push_back({1'b1, 16'hB001});
            present();
            checks++;
            if ({grant, in_ready, out_flit, locked, err_timeout} !==
                {exp_grant, exp_ready, exp_out, exp_locked, m_err}) begin
                errors++;
                $display("FAIL worm_lock c%0d: got g=%b r=%b o=%h l=%b, want g=%b r=%b o=%h l=%b",
                         c, grant, in_ready, out_flit, locked, exp_grant, exp_ready, exp_out, exp_locked);
            end
            if (c < 3) begin
                checks++;
                if (in_ready[2] !== 1'b0) begin
                    errors++;
                    $display("FAIL worm_lock_ready2 c%0d: got %b, want 0", c, in_ready[2]);
                end
            end
            if (out_flit.valid && out_ready && k < 4) begin
                checks++;
                if (out_flit.data !== seq[k]) begin
                    errors++;
                    $display("FAIL worm_order #%0d: got %h, want %h", k, out_flit.data, seq[k]);
                end
                k++;
            end
            advance();
        end
        checks++;
        if (k != 4) begin
            errors++;
            $display("FAIL worm_count: got %0d flits, want 4", k);
        end
    endtask

    task automatic test_held_offer();
        logic [N-1:0] want [6];
        want = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b001};
        do_reset();
        out_ready = 1'b0;
        srcq[1].push_back({1'b1, 16'h2001});
        for (int c = 0; c < 6; c++) begin
            if (c == 1) srcq[0].push_back({1'b1, 16'h2000});
            out_ready = (c >= 4);
            present();
            checks++;
            if (grant !== want[c] || {in_ready, out_flit, locked} !== {exp_ready, exp_out, exp_locked}) begin
                errors++;
                $display("FAIL held_offer c%0d: got g=%b r=%b o=%h l=%b, want g=%b r=%b o=%h l=%b",
                         c, grant, in_ready, out_flit, locked, want[c], exp_ready, exp_out, exp_locked);
            end
            advance();
        end
    endtask

    task automatic test_enable_mask();
        logic [N-1:0] want [3];
        want = '{3'b010, 3'b010, 3'b001};
        do_reset();
        in_enable = 3'b110;
        for (int j = 0; j < 3; j++) begin
            srcq[0].push_back({1'b1, 16'h3000 + 16'(j)});
            srcq[1].push_back({1'b1, 16'h3100 + 16'(j)});
        end
        for (int c = 0; c < 7; c++) begin
            if (c == 2) in_enable = 3'b111;
            present();
            checks++;
            if ((c < 3 && grant !== want[c]) ||
                {grant, in_ready, out_flit, locked} !== {exp_grant, exp_ready, exp_out, exp_locked}) begin
                errors++;
                $display("FAIL enable_mask c%0d: got g=%b r=%b o=%h, want g=%b r=%b o=%h",
                         c, grant, in_ready, out_flit, exp_grant, exp_ready, exp_out);
            end
            advance();
        end
    endtask

    task automatic test_timeout();
        bit want_err [10];
        want_err = '{0, 0, 0, 0, 0, 1, 0, 1, 1, 1};
        do_reset();
        srcq[2].push_back({1'b0, 16'h4001});
        srcq[2].push_back({1'b1, 16'h4002});
        for (int c = 0; c < 10; c++) begin
            gap[2]    = (c >= 1 && c <= 7);
            err_clear = (c == 5);
            if (c == 9)
                for (int i = 0; i < N; i++) srcq[i].push_back({1'b1, 16'h4100 + 16'(i)});
            present();
            checks++;
            if (err_timeout !== want_err[c] || locked !== (c >= 1 && c <= 8) || (c == 9 && grant !== 3'b001)) begin
                errors++;
                $display("FAIL timeout c%0d: got err=%b locked=%b grant=%b, want err=%b locked=%b",
                         c, err_timeout, locked, grant, want_err[c], (c >= 1 && c <= 8));
            end
            checks++;
            if ({grant, in_ready, out_flit, locked, err_timeout} !==
                {exp_grant, exp_ready, exp_out, exp_locked, m_err}) begin
                errors++;
                $display("FAIL timeout_model c%0d: got g=%b r=%b o=%h l=%b e=%b, want g=%b r=%b o=%h l=%b e=%b",
                         c, grant, in_ready, out_flit, locked, err_timeout,
                         exp_grant, exp_ready, exp_out, exp_locked, m_err);
            end
            advance();
        end
        err_clear = 1'b0;
    endtask

    task automatic test_reset_mid_worm();
        do_reset();
        for (int j = 0; j < 4; j++) srcq[1].push_back({(j == 3), 16'h5000 + 16'(j)});
        present();
        advance();
        rst = 1'b1;
        present();
        srcq[1].delete();
        srcq[0].push_back({1'b1, 16'h5100});
        advance();
        rst = 1'b0;
        present();
        checks++;
        if (locked !== 1'b0 || grant !== 3'b001 || out_flit.data !== 16'h5100) begin
            errors++;
            $display("FAIL reset_mid_worm: got locked=%b grant=%b data=%h, want locked=0 grant=001 data=5100",
                     locked, grant, out_flit.data);
        end
        advance();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < N; i++) begin
                if (srcq[i].size() == 0 && $urandom_range(0, 2) == 0) begin
                    int len = $urandom_range(1, 4);
                    for (int j = 0; j < len; j++)
                        srcq[i].push_back({(j == len - 1), 16'($urandom)});
                end
                if ($urandom_range(0, 5) == 0) gap[i] = !gap[i];
            end
            out_ready = ($urandom_range(0, 3) != 0);
            in_enable = N'($urandom);
            err_clear = ($urandom_range(0, 15) == 0);
            present();
            checks++;
            if ({grant, in_ready, out_flit, locked, err_timeout} !==
                {exp_grant, exp_ready, exp_out, exp_locked, m_err}) begin
                errors++;
                $display("FAIL random c%0d: got g=%b r=%b o=%h l=%b e=%b, want g=%b r=%b o=%h l=%b e=%b",
                         c, grant, in_ready, out_flit, locked, err_timeout,
                         exp_grant, exp_ready, exp_out, exp_locked, m_err);
            end
            advance();
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            in_flit[i] = '0;
            gap[i] = 0;
        end
        test_reset();
        test_round_robin();
        test_worm_lock();
        test_held_offer();
        test_enable_mask();
        test_timeout();
        test_reset_mid_worm();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
